// File: rtl/expr_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | expr_pkg : shared encodings for the expression syntax checker             |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package expr_pkg;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_NUM   = 2'd1;
  localparam logic [1:0] S_CLOSE = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  typedef enum logic [2:0] {
    CLS_DIG = 3'd0,
    CLS_OP  = 3'd1,
    CLS_LP  = 3'd2,
    CLS_RP  = 3'd3,
    CLS_BAD = 3'd4
  } char_class_e;

  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_LPAREN = 8'h28;
  localparam logic [7:0] ASCII_RPAREN = 8'h29;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/expr_char_class.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | expr_char_class : combinational ASCII character classifier                |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module expr_char_class
  import expr_pkg::*;
#(
  parameter int ALLOW_SUB   = 1,
  parameter int ALLOW_PAREN = 1
) (
  input  logic [7:0]  in,
  output char_class_e cls
);

  always_comb begin
    cls = CLS_BAD;
    if (is_digit(in)) begin
      cls = CLS_DIG;
    end else if ((in == ASCII_PLUS) || (in == ASCII_STAR)) begin
      cls = CLS_OP;
    end else if ((ALLOW_SUB != 0) && (in == ASCII_MINUS)) begin
      cls = CLS_OP;
    end else if ((ALLOW_PAREN != 0) && (in == ASCII_LPAREN)) begin
      cls = CLS_LP;
    end else if ((ALLOW_PAREN != 0) && (in == ASCII_RPAREN)) begin
      cls = CLS_RP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/expr_checker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | expr_checker : streaming syntax checker for ASCII arithmetic expressions  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module expr_checker
  import expr_pkg::*;
#(
  parameter int DEPTH_W     = 4,
  parameter int MAX_DIGITS  = 4,
  parameter int ALLOW_SUB   = 1,
  parameter int ALLOW_PAREN = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  input  logic               restart,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] c_depth_max  = '1;
  localparam logic [3:0]         c_max_digits = 4'(MAX_DIGITS);

  logic [1:0]         r_state, w_state_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic [3:0]         r_cnt,   w_cnt_nxt;
  char_class_e        w_cls;

  expr_char_class #(
    .ALLOW_SUB   (ALLOW_SUB),
    .ALLOW_PAREN (ALLOW_PAREN)
  ) u_char_class (
    .in  (in),
    .cls (w_cls)
  );

  // Error transitions leave depth and digit count untouched so they freeze.
  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_START: begin
        if (w_cls == CLS_DIG) begin
          w_state_nxt = S_NUM;
          w_cnt_nxt   = 4'd1;
        end else if ((w_cls == CLS_LP) && (r_depth != c_depth_max)) begin
          w_depth_nxt = r_depth + 1'b1;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_NUM: begin
        if ((w_cls == CLS_DIG) && (r_cnt != c_max_digits)) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_cls == CLS_OP) begin
          w_state_nxt = S_START;
        end else if ((w_cls == CLS_RP) && (r_depth != '0)) begin
          w_state_nxt = S_CLOSE;
          w_depth_nxt = r_depth - 1'b1;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_CLOSE: begin
        if (w_cls == CLS_OP) begin
          w_state_nxt = S_START;
        end else if ((w_cls == CLS_RP) && (r_depth != '0)) begin
          w_depth_nxt = r_depth - 1'b1;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_START;
      r_depth <= '0;
      r_cnt   <= '0;
    end else if (restart) begin
      r_state <= S_START;
      r_depth <= '0;
      r_cnt   <= '0;
    end else if (in_valid) begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out   = ((r_state == S_NUM) || (r_state == S_CLOSE)) && (r_depth == '0);
  assign err   = (r_state == S_ERR);
  assign depth = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_expr_checker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_expr_checker : randomized + directed bench with a string-level model   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_expr_checker;
  import expr_pkg::*;

  localparam int DW       = 4;
  localparam int MAXD     = 4;
  localparam int MAXDEPTH = (1 << DW) - 1;

  logic          clk      = 1'b0;
  logic          clr      = 1'b1;
  logic          in_valid = 1'b0;
  logic          restart  = 1'b0;
  logic [7:0]    in_ch    = 8'h00;
  logic          out_a, err_a, out_b, err_b;
  logic [DW-1:0] depth_a, depth_b;
  logic [7:0]    cc_in    = 8'h00;
  char_class_e   cls_full, cls_min;

  int n_checks = 0;
  int n_pass   = 0;

  // Full-featured instance and one with '-' and parentheses disabled.
  expr_checker #(.DEPTH_W(DW), .MAX_DIGITS(MAXD), .ALLOW_SUB(1), .ALLOW_PAREN(1)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch), .restart(restart),
    .out(out_a), .err(err_a), .depth(depth_a)
  );
  expr_checker #(.DEPTH_W(DW), .MAX_DIGITS(MAXD), .ALLOW_SUB(0), .ALLOW_PAREN(0)) dut_ns (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch), .restart(restart),
    .out(out_b), .err(err_b), .depth(depth_b)
  );
  expr_char_class #(.ALLOW_SUB(1), .ALLOW_PAREN(1)) u_cc_full (.in(cc_in), .cls(cls_full));
  expr_char_class #(.ALLOW_SUB(0), .ALLOW_PAREN(0)) u_cc_min  (.in(cc_in), .cls(cls_min));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Characters accepted since the last reset/restart; the model re-parses them.
  byte unsigned q[$];

  always @(posedge clk or negedge clr) begin
    if (!clr) q.delete();
    else if (restart) q.delete();
    else if (in_valid) q.push_back(in_ch);
  end

  function automatic char_class_e exp_cls(input byte unsigned c, input bit sub, input bit par);
    if (c >= 8'd48 && c <= 8'd57) return CLS_DIG;
    if (c == 8'd43 || c == 8'd42) return CLS_OP;
    if (c == 8'd45) return sub ? CLS_OP : CLS_BAD;
    if (c == 8'd40) return par ? CLS_LP : CLS_BAD;
    if (c == 8'd41) return par ? CLS_RP : CLS_BAD;
    return CLS_BAD;
  endfunction

  // Token-level grammar walk over the accepted string.
  function automatic void model(input bit sub, input bit par, output int o, output int e, output int d);
    bit need_operand = 1'b1;
    bit after_close  = 1'b0;
    int digits = 0;
    int dep    = 0;
    bit bad    = 1'b0;
    char_class_e k;
    foreach (q[i]) begin
      if (bad) break;
      k = exp_cls(q[i], sub, par);
      if (need_operand) begin
        if (k == CLS_DIG) begin need_operand = 0; digits = 1; end
        else if (k == CLS_LP && dep < MAXDEPTH) dep++;
        else bad = 1;
      end else if (after_close) begin
        if (k == CLS_OP) begin need_operand = 1; after_close = 0; end
        else if (k == CLS_RP && dep > 0) dep--;
        else bad = 1;
      end else begin
        if (k == CLS_DIG && digits < MAXD) digits++;
        else if (k == CLS_OP) need_operand = 1;
        else if (k == CLS_RP && dep > 0) begin dep--; after_close = 1; end
        else bad = 1;
      end
    end
    e = bad ? 1 : 0;
    o = (!bad && !need_operand && dep == 0) ? 1 : 0;
    d = dep;
  endfunction

  task automatic compare_all();
    int o, e, d;
    model(1'b1, 1'b1, o, e, d);
    chk("model_out_a", out_a, o);
    chk("model_err_a", err_a, e);
    chk("model_depth_a", depth_a, d);
    model(1'b0, 1'b0, o, e, d);
    chk("model_out_b", out_b, o);
    chk("model_err_b", err_b, e);
    chk("model_depth_b", depth_b, d);
  endtask

  always @(negedge clk) compare_all();

  task automatic put(input byte unsigned c);
    in_ch = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic puts(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic idle();
    in_ch = "x"; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_restart(input byte unsigned c, input bit v);
    restart = 1'b1; in_ch = c; in_valid = v;
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
  endtask

  task automatic lit(input string name, input int o, input int e, input int d);
    chk({name, "_out"}, out_a, o);
    chk({name, "_err"}, err_a, e);
    chk({name, "_depth"}, depth_a, d);
  endtask

  initial begin
    #1 clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cc_in = 8'(i); #1;
      chk("cls_full", int'(cls_full), int'(exp_cls(8'(i), 1'b1, 1'b1)));
      chk("cls_min",  int'(cls_min),  int'(exp_cls(8'(i), 1'b0, 1'b0)));
    end
    repeat (2) @(posedge clk); #1;
    lit("reset", 0, 0, 0);
    clr = 1'b1;

    put("1"); lit("t1_1", 1, 0, 0);
    put("2"); lit("t1_2", 1, 0, 0);
    put("+"); lit("t1_plus", 0, 0, 0);
    put("3"); lit("t1_3", 1, 0, 0);

    do_restart(8'h00, 1'b0);
    puts("1234"); lit("t2_4dig", 1, 0, 0);
    put("5");     lit("t2_5dig", 0, 1, 0);
    put("6");     lit("t2_6dig", 0, 1, 0);

    do_restart(8'h00, 1'b0);
    put("("); lit("t3_lp1", 0, 0, 1);
    put("("); lit("t3_lp2", 0, 0, 2);
    put("7"); lit("t3_7", 0, 0, 2);
    put(")"); lit("t3_rp1", 0, 0, 1);
    put("*"); lit("t3_star", 0, 0, 1);
    put("2"); lit("t3_2", 0, 0, 1);
    put(")"); lit("t3_rp0", 1, 0, 0);
    put(")"); lit("t3_under", 0, 1, 0);

    do_restart(8'h00, 1'b0);
    put("5"); put("-");
    chk("t4_nosub_err", err_b, 1);
    put("3"); lit("t4_sub", 1, 0, 0);
    do_restart(8'h00, 1'b0);
    put("(");
    chk("t4_noparen_err", err_b, 1);

    do_restart(8'h00, 1'b0);
    put("9");
    for (int i = 0; i < 3; i++) begin idle(); chk("t5_gap_out", out_a, 1); end
    put("+"); put("1"); lit("t5_after_gap", 1, 0, 0);
    put("+"); put("+"); lit("t5_err", 0, 1, 0);
    do_restart("4", 1'b1); lit("t5_restart", 0, 0, 0);
    idle(); lit("t5_4_dropped", 0, 0, 0);

    do_restart(8'h00, 1'b0);
    for (int i = 0; i < MAXDEPTH; i++) put("(");
    lit("ovf_max", 0, 0, MAXDEPTH);
    put("("); lit("ovf_err", 0, 1, MAXDEPTH);

    do_restart(8'h00, 1'b0);
    puts("((("); lit("t6_depth3", 0, 0, 3);
    @(negedge clk); #2 clr = 1'b0;
    #1 lit("t6_async", 0, 0, 0);
    @(posedge clk); #1 clr = 1'b1;
    put("8"); lit("t6_8", 1, 0, 0);
    @(negedge clk); #2 clr = 1'b0;
    #1 chk("t6_async_out", out_a, 0);
    @(posedge clk); #1 clr = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      int k;
      restart  = ($urandom_range(0, 99) < 4);
      in_valid = ($urandom_range(0, 4) != 0);
      k = $urandom_range(0, 99);
      if (k < 40)      in_ch = 8'(8'd48 + $urandom_range(0, 9));
      else if (k < 50) in_ch = "+";
      else if (k < 55) in_ch = "*";
      else if (k < 60) in_ch = "-";
      else if (k < 75) in_ch = "(";
      else if (k < 90) in_ch = ")";
      else             in_ch = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    restart = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
